// File: rtl/maxpool_window_packer_pkg.sv
// rtl/maxpool_window_packer_pkg.sv - window geometry constants and packer state enum
package maxpool_window_packer_pkg;

   localparam int DATA_WIDTH = 16;
   localparam int SIZE       = 13;
   localparam int WIN_ELEMS  = SIZE * SIZE;
   localparam int WIN_BITS   = DATA_WIDTH * WIN_ELEMS;
   localparam int CNT_WIDTH  = $clog2(WIN_ELEMS + 1);

   typedef logic [CNT_WIDTH-1:0] fillCount_t;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } packerState_t;

endpackage

// File: rtl/maxpool_window_packer_if.sv
// rtl/maxpool_window_packer_if.sv - element stream in, flattened window out
interface maxpool_window_packer_if
   import maxpool_window_packer_pkg::*;
#(
   parameter int DATA_WIDTH = maxpool_window_packer_pkg::DATA_WIDTH,
   parameter int SIZE       = maxpool_window_packer_pkg::SIZE
);

   logic                              in_valid;
   logic                              in_ready;
   logic [DATA_WIDTH-1:0]             in_data;
   logic                              in_last;
   logic                              win_valid;
   logic                              win_ready;
   logic [DATA_WIDTH*SIZE*SIZE-1:0]   win_data;

   // master is the surrounding system: feature-map reader plus MaxUnit13
   modport master (
      output in_valid, in_data, in_last, win_ready,
      input  in_ready, win_valid, win_data
   );

   modport slave (
      input  in_valid, in_data, in_last, win_ready,
      output in_ready, win_valid, win_data
   );

endinterface

// File: rtl/maxpool_window_packer_window_slot_bank.sv
// rtl/maxpool_window_packer_window_slot_bank.sv - window register file with one-hot slot write
module window_slot_bank
   import maxpool_window_packer_pkg::*;
#(
   parameter int DATA_WIDTH = maxpool_window_packer_pkg::DATA_WIDTH,
   parameter int WIN_ELEMS  = maxpool_window_packer_pkg::WIN_ELEMS,
   parameter int CNT_WIDTH  = maxpool_window_packer_pkg::CNT_WIDTH
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            wrEn,
   input  logic [CNT_WIDTH-1:0]            wrSlot,
   input  logic [DATA_WIDTH-1:0]           wrData,
   output logic [DATA_WIDTH*WIN_ELEMS-1:0] winData
);

   logic [WIN_ELEMS-1:0]            slotSel;
   logic [DATA_WIDTH*WIN_ELEMS-1:0] bank;

   always_comb begin
      slotSel = '0;
      for (int k = 0; k < WIN_ELEMS; k++) begin
         slotSel[k] = wrEn && (wrSlot == CNT_WIDTH'(k));
      end
   end

   // slots are never cleared between windows; only reset zeroes them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank <= '0;
      end else begin
         for (int k = 0; k < WIN_ELEMS; k++) begin
            if (slotSel[k]) begin
               bank[k*DATA_WIDTH +: DATA_WIDTH] <= wrData;
            end
         end
      end
   end

   assign winData = bank;

endmodule

// File: rtl/maxpool_window_packer.sv
// rtl/maxpool_window_packer.sv - packs a row-major FP16 element stream into one SIZExSIZE window for MaxUnit13
module maxpool_window_packer
   import maxpool_window_packer_pkg::*;
#(
   parameter int DATA_WIDTH = maxpool_window_packer_pkg::DATA_WIDTH,
   parameter int SIZE       = maxpool_window_packer_pkg::SIZE,
   parameter int CHECK_LAST = 1
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               clear,
   maxpool_window_packer_if.slave             bus,
   output logic [$clog2(SIZE*SIZE+1)-1:0]     fill_count,
   output logic                               frame_err
);

   localparam int N  = SIZE * SIZE;
   localparam int CW = $clog2(N + 1);

   typedef logic [CW-1:0] count_t;

   packerState_t state;
   packerState_t stateNext;
   count_t       fillCount;
   count_t       fillNext;
   logic         frameErrQ;
   logic         errNext;
   logic         accept;
   logic         lastSlot;
   logic         earlyLast;
   logic         wrEn;

   assign bus.in_ready  = (state == FILL) && !clear;
   assign bus.win_valid = (state == HOLD);

   assign accept    = bus.in_valid && bus.in_ready;
   assign lastSlot  = (fillCount == count_t'(N - 1));
   assign earlyLast = (CHECK_LAST != 0) && bus.in_last && !lastSlot;
   // an element carrying a premature last is dropped, not written
   assign wrEn      = accept && !earlyLast;

   always_comb begin
      stateNext = state;
      fillNext  = fillCount;
      errNext   = 1'b0;
      if (clear) begin
         stateNext = FILL;
         fillNext  = '0;
      end else begin
         case (state)
            FILL: begin
               if (accept) begin
                  if (earlyLast) begin
                     fillNext = '0;
                     errNext  = 1'b1;
                  end else begin
                     fillNext = fillCount + count_t'(1);
                     if (lastSlot) begin
                        stateNext = HOLD;
                        errNext   = (CHECK_LAST != 0) && !bus.in_last;
                     end
                  end
               end
            end
            HOLD: begin
               if (bus.win_ready) begin
                  stateNext = FILL;
                  fillNext  = '0;
               end
            end
            default: begin
               stateNext = FILL;
               fillNext  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= FILL;
         fillCount <= '0;
         frameErrQ <= 1'b0;
      end else begin
         state     <= stateNext;
         fillCount <= fillNext;
         frameErrQ <= errNext;
      end
   end

   assign fill_count = fillCount;
   assign frame_err  = frameErrQ;

   window_slot_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .WIN_ELEMS  (N),
      .CNT_WIDTH  (CW)
   ) uSlotBank (
      .clk     (clk),
      .rst_n   (rst_n),
      .wrEn    (wrEn),
      .wrSlot  (fillCount),
      .wrData  (bus.in_data),
      .winData (bus.win_data)
   );

endmodule

// File: doc/maxpool_window_packer.md
Name: maxpool_window_packer

Overview:
- Streaming producer for the 13x13 FP16 max-pool reducer (MaxUnit13).
- Accepts one FP16 element per cycle over a valid/ready handshake and assembles a flattened 169-element window bus (2704 bits).
- Presents the window to the reducer with a valid/ready handshake and holds it stable until the window is accepted.
- Sits between the feature-map read path and MaxUnit13 in the YOLO SPP/max-pool stage.

Parameters:
- DATA_WIDTH, 16, element width (FP16 bit pattern, not interpreted).
- SIZE, 13, window edge; window holds SIZE*SIZE elements.
- CHECK_LAST, 1, when 1 in_last is checked for framing; when 0 in_last is ignored.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush; discards any partial or held window.
- in_valid  in  1  input element valid.
- in_ready  out  1  packer can accept an element.
- in_data  in  DATA_WIDTH  input element, row-major order (row r, col c arrives as k = r*SIZE+c).
- in_last  in  1  marks the final element (k = SIZE*SIZE-1) of a window.
- win_valid  out  1  complete window present on win_data.
- win_ready  in  1  consumer accepts the window.
- win_data  out  DATA_WIDTH*SIZE*SIZE  flattened window; element k at bits [DATA_WIDTH*k+DATA_WIDTH-1 : DATA_WIDTH*k].
- fill_count  out  $clog2(SIZE*SIZE+1)  number of elements accepted into the current window.
- frame_err  out  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=FILL, fill_count=0, win_valid=0, frame_err=0, win_data=0.
  - in_ready is 1 on the first cycle after reset release.
- FSM has two states, FILL and HOLD. in_ready = (state==FILL) && !clear. win_valid = (state==HOLD).
- FILL:
  - On in_valid && in_ready, write in_data to slot fill_count and increment fill_count.
  - When the accepted element is slot N-1 (N = SIZE*SIZE), go to HOLD next cycle and set win_valid=1.
  - Latency from the last accept edge to win_valid=1 is one cycle.
- HOLD:
  - in_ready=0. win_data and win_valid stay stable while win_ready=0.
  - On win_valid && win_ready, go to FILL and set fill_count=0 next cycle.
  - No element is accepted in the handshake cycle. Minimum period is N+1 cycles per window.
- win_data outside HOLD is partially overwritten and undefined for the consumer. Slots not yet rewritten keep their old values; there is no zeroing between windows.
- Framing, when CHECK_LAST=1:
  - in_last accepted at slot k < N-1: frame_err pulses next cycle, the element is discarded, fill_count returns to 0, state stays FILL.
  - Slot N-1 accepted with in_last=0: window is still emitted (HOLD) and frame_err pulses in the same cycle win_valid rises.
  - When CHECK_LAST=0, frame_err is never asserted.
- clear=1 in any state:
  - Next cycle: state=FILL, fill_count=0, win_valid=0.
  - Any element presented with clear=1 is not accepted, because in_ready=0.
  - clear has priority over in_last checking and over the win handshake. frame_err is not raised by clear.
- Reset mid-fill or mid-hold discards all progress immediately, with no output glitch beyond forcing outputs to reset values.
- in_valid gaps in FILL are allowed with no effect. in_valid while in HOLD is ignored, and the element stays with the upstream producer.
- win_ready while in FILL is ignored.

Decomposition:
- Shared package: DATA_WIDTH, SIZE, WIN_ELEMS = SIZE*SIZE, WIN_BITS = DATA_WIDTH*WIN_ELEMS, fill counter width, and the FILL/HOLD state enum.
- Both MaxUnit13 and the packer use these constants.
- One sub-module: window_slot_bank, the WIN_ELEMS x DATA_WIDTH register file with a write-enable and a one-hot slot decode from fill_count, exposing the flattened bus.
- The FSM, counter and framing logic stay in the top module.

Test Plan:
- Fill and emit: reset, then 169 elements of 16'h4000 except k=100 = 16'h4500, with in_last on k=168, win_ready=1 -> win_valid high for exactly 1 cycle, one cycle after the 169th accept. win_data[1615:1600]=16'h4500, all other slots 16'h4000, MaxOut from MaxUnit13 = 16'h4500.
- Backpressure: full window, then win_ready=0 for 5 cycles -> win_valid=1 and in_ready=0 throughout, win_data bit-stable. Raise win_ready -> fill_count=0 and in_ready=1 next cycle.
- Early last: in_last with element k=49 -> frame_err pulse of 1 cycle, fill_count=0. Next 169 elements form a correct window.
- Missing last: 169 elements with in_last=0 -> win_valid=1 and frame_err=1 in the same cycle. With CHECK_LAST=0 the same stimulus gives frame_err=0.
- clear in HOLD and mid-fill (fill_count=80) -> next cycle win_valid=0 and fill_count=0. An element presented with clear=1 is not counted.
- Async reset asserted mid-cycle at fill_count=120 -> outputs at reset values immediately, before the next clock edge. After release, a full window of random FP16 values round-trips in slot order.
